// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared types and constants for the Triple-DES control
//                sequencer: state encoding, key-schedule shift table and
//                the EDE pass-to-key/direction mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int ROUNDS_PER_PASS = 16;
    localparam int NUM_PASSES      = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } tdes_state_t;

    // Per-round left-rotate amounts of the DES key schedule, index = round.
    // Listed from round 15 down to round 0.
    localparam logic [15:0][1:0] LSHIFT = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };

    // EDE pass mapping. Returns {key_sel[1:0], pass_dec}.
    // Encrypt: E/K1, D/K2, E/K3.  Decrypt: D/K3, E/K2, D/K1.
    function automatic logic [2:0] pass_map(input logic mode, input logic [1:0] pass_idx);
        logic [1:0] sel;
        logic       dec;
        if (mode) begin
            sel = pass_idx;
            dec = pass_idx[0];
        end else begin
            sel = 2'd2 - pass_idx;
            dec = ~pass_idx[0];
        end
        return {sel, dec};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdes_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdes_ctrl_if
//  Description : Host handshake and round-datapath control bundle of the
//                Triple-DES sequencer. The slave modport is the sequencer;
//                the master modport is the host/datapath side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tdes_ctrl_if;

    logic       start;
    logic       encrypt;
    logic       abort;
    logic       busy;
    logic       done;
    logic       load_data;
    logic       key_load;
    logic       round_en;
    logic       fp_en;
    logic [3:0] round_idx;
    logic [1:0] pass_idx;
    logic [1:0] key_sel;
    logic       pass_dec;
    logic [1:0] shift_amt;
    logic       shift_left;

    modport master (
        output start, encrypt, abort,
        input  busy, done, load_data, key_load, round_en, fp_en,
        input  round_idx, pass_idx, key_sel, pass_dec, shift_amt, shift_left
    );

    modport slave (
        input  start, encrypt, abort,
        output busy, done, load_data, key_load, round_en, fp_en,
        output round_idx, pass_idx, key_sel, pass_dec, shift_amt, shift_left
    );

endinterface
`default_nettype wire

// File: rtl/des_shift_lut.sv
`default_nettype none
// ============================================================================
//  Module      : des_shift_lut
//  Description : Key-register rotate amount for a round. Encrypt passes use
//                the schedule forwards; decrypt passes walk it backwards
//                with no rotation on round 0 (the loaded key is K16's).
//  Revision    : 1.0 - initial release
// ============================================================================
module des_shift_lut
    import des_pkg::*;
(
    input  logic [3:0] round_idx,
    input  logic       pass_dec,
    output logic [1:0] shift_amt
);

    logic [3:0] lut_idx;

    // Decrypt round r uses LSHIFT[16-r]; 4-bit wraparound of 0-r gives that.
    always_comb begin
        lut_idx   = pass_dec ? (4'd0 - round_idx) : round_idx;
        shift_amt = (pass_dec && (round_idx == 4'd0)) ? 2'd0 : LSHIFT[lut_idx];
    end

endmodule
`default_nettype wire

// File: rtl/tdes_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tdes_ctrl
//  Description : Triple-DES control sequencer. Runs three 16-round DES
//                passes in EDE order and drives the round datapath and key
//                schedule controls. Every output is a flop loaded from the
//                decode of the next state, so outputs are glitch-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdes_ctrl
    import des_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_PER_PASS,
    parameter int PASSES = NUM_PASSES
) (
    input  logic        clk,
    input  logic        n_rst,
    tdes_ctrl_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [1:0] LAST_PASS  = 2'(PASSES - 1);

    tdes_state_t state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [1:0]  pass_q, pass_d;
    logic        mode_q, mode_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        load_data_q, load_data_d;
    logic        key_load_q, key_load_d;
    logic        round_en_q, round_en_d;
    logic        fp_en_q, fp_en_d;
    logic [3:0]  round_idx_q, round_idx_d;
    logic [1:0]  pass_idx_q, pass_idx_d;
    logic [1:0]  key_sel_q, key_sel_d;
    logic        pass_dec_q, pass_dec_d;
    logic [1:0]  shift_amt_q, shift_amt_d;
    logic        shift_left_q, shift_left_d;

    logic [2:0]  map_next;
    logic [1:0]  lut_amt;

    // Next-state sequencing; abort overrides every transition once busy.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        pass_d  = pass_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    round_d = 4'd0;
                    pass_d  = 2'd0;
                    mode_d  = bus.encrypt;
                end
            end
            ST_LOAD: begin
                state_d = ST_ROUND;
                round_d = 4'd0;
            end
            ST_ROUND: begin
                if (round_q == LAST_ROUND) begin
                    state_d = ST_FINAL;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_FINAL: begin
                if (pass_q == LAST_PASS) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                    pass_d  = pass_q + 2'd1;
                end
            end
            ST_DONE: begin
                // The DONE cycle closes the block, so a start here chains
                // straight into the next one (55-cycle throughput).
                round_d = 4'd0;
                pass_d  = 2'd0;
                if (bus.start) begin
                    state_d = ST_LOAD;
                    mode_d  = bus.encrypt;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 4'd0;
                pass_d  = 2'd0;
            end
        endcase
        if ((state_q != ST_IDLE) && bus.abort) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            pass_d  = 2'd0;
        end
    end

    assign map_next = pass_map(mode_d, pass_d);

    des_shift_lut u_shift_lut (
        .round_idx (round_d),
        .pass_dec  (map_next[0]),
        .shift_amt (lut_amt)
    );

    // Output decode of the next state; pass controls are zero outside a pass.
    always_comb begin
        logic in_pass;
        in_pass      = (state_d == ST_LOAD) || (state_d == ST_ROUND) || (state_d == ST_FINAL);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        load_data_d  = (state_d == ST_LOAD);
        key_load_d   = (state_d == ST_LOAD);
        round_en_d   = (state_d == ST_ROUND);
        fp_en_d      = (state_d == ST_FINAL);
        round_idx_d  = (state_d == ST_ROUND) ? round_d : 4'd0;
        shift_amt_d  = (state_d == ST_ROUND) ? lut_amt : 2'd0;
        pass_idx_d   = in_pass ? pass_d : 2'd0;
        key_sel_d    = in_pass ? map_next[2:1] : 2'd0;
        pass_dec_d   = in_pass & map_next[0];
        shift_left_d = in_pass & ~map_next[0];
    end

    // State, counters, latched mode and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            round_q      <= 4'd0;
            pass_q       <= 2'd0;
            mode_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_data_q  <= 1'b0;
            key_load_q   <= 1'b0;
            round_en_q   <= 1'b0;
            fp_en_q      <= 1'b0;
            round_idx_q  <= 4'd0;
            pass_idx_q   <= 2'd0;
            key_sel_q    <= 2'd0;
            pass_dec_q   <= 1'b0;
            shift_amt_q  <= 2'd0;
            shift_left_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            pass_q       <= pass_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
            key_load_q   <= key_load_d;
            round_en_q   <= round_en_d;
            fp_en_q      <= fp_en_d;
            round_idx_q  <= round_idx_d;
            pass_idx_q   <= pass_idx_d;
            key_sel_q    <= key_sel_d;
            pass_dec_q   <= pass_dec_d;
            shift_amt_q  <= shift_amt_d;
            shift_left_q <= shift_left_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_data  = load_data_q;
    assign bus.key_load   = key_load_q;
    assign bus.round_en   = round_en_q;
    assign bus.fp_en      = fp_en_q;
    assign bus.round_idx  = round_idx_q;
    assign bus.pass_idx   = pass_idx_q;
    assign bus.key_sel    = key_sel_q;
    assign bus.pass_dec   = pass_dec_q;
    assign bus.shift_amt  = shift_amt_q;
    assign bus.shift_left = shift_left_q;

endmodule
`default_nettype wire

// File: tb/tb_tdes_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdes_ctrl
//  Description : Self-checking bench for tdes_ctrl. Expected outputs come
//                from a timeline model: cycle k of an operation (k = 1..55)
//                maps to pass (k-1)/18 and slot (k-1)%18.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdes_ctrl;

    logic clk;
    logic n_rst;

    tdes_ctrl_if bus ();

    tdes_ctrl dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Sequences taken from the operation description.
    int key_enc [3]  = '{0, 1, 2};
    int key_dec [3]  = '{2, 1, 0};
    int dec_enc [3]  = '{0, 1, 0};
    int dec_dec [3]  = '{1, 0, 1};
    int sh_enc  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int sh_dec  [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // {busy,done,load_data,key_load,round_en,fp_en,round_idx,pass_idx,key_sel,pass_dec,shift_amt,shift_left}
    function automatic logic [17:0] observed();
        return {bus.busy, bus.done, bus.load_data, bus.key_load, bus.round_en, bus.fp_en,
                bus.round_idx, bus.pass_idx, bus.key_sel, bus.pass_dec, bus.shift_amt, bus.shift_left};
    endfunction

    // Expected outputs for cycle k of an operation; k = 0 means idle.
    function automatic logic [17:0] model(input int k, input bit enc);
        logic b, d, ld, kl, re, fe, pd, sl;
        logic [3:0] ri;
        logic [1:0] pi, ks, sa;
        int p, off;
        {b, d, ld, kl, re, fe, pd, sl} = '0;
        ri = '0; pi = '0; ks = '0; sa = '0;
        if (k >= 1 && k <= 54) begin
            p   = (k - 1) / 18;
            off = (k - 1) % 18;
            b   = 1'b1;
            pi  = 2'(p);
            ks  = 2'(enc ? key_enc[p] : key_dec[p]);
            pd  = (enc ? dec_enc[p] : dec_dec[p]) != 0;
            sl  = ~pd;
            if (off == 0) begin
                ld = 1'b1;
                kl = 1'b1;
            end else if (off == 17) begin
                fe = 1'b1;
            end else begin
                re = 1'b1;
                ri = 4'(off - 1);
                sa = 2'(pd ? sh_dec[off - 1] : sh_enc[off - 1]);
            end
        end else if (k == 55) begin
            b = 1'b1;
            d = 1'b1;
        end
        return {b, d, ld, kl, re, fe, ri, pi, ks, pd, sa, sl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int k, input bit enc);
        logic [17:0] o, e;
        o = observed();
        e = model(k, enc);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
        end
    endtask

    // Runs one operation; the caller has already raised start/encrypt.
    // stim: 0 quiet, 1 random start/encrypt noise, 2 start held high.
    // abort_k: cycle after which abort is pulsed (0 = none).
    task automatic run_op(input string tag, input bit enc, input int stim,
                          input int abort_k, input bit chain, input bit chain_enc);
        for (int k = 1; k <= 55; k++) begin
            step();
            check(tag, k, enc);
            bus.abort = 1'b0;
            bus.start = (stim == 2);
            if (stim == 1 && k <= 54) begin
                bus.start   = 1'($urandom);
                bus.encrypt = 1'($urandom);
            end
            if (k == abort_k) begin
                bus.abort = 1'b1;
                bus.start = 1'b0;
                step();
                bus.abort = 1'b0;
                check({tag, "_abort"}, 0, enc);
                return;
            end
            if (k == 55) begin
                bus.start   = chain;
                bus.encrypt = chain_enc;
            end
        end
    endtask

    initial begin
        bit m0, m1, m2;
        int ak;
        n_rst       = 1'b0;
        bus.start   = 1'b0;
        bus.encrypt = 1'b0;
        bus.abort   = 1'b0;

        // Reset state, also with start asserted during reset.
        repeat (3) step();
        check("reset", 0, 1'b1);
        bus.start = 1'b1;
        step();
        check("reset_start", 0, 1'b1);
        bus.start = 1'b0;
        n_rst     = 1'b1;
        step();
        check("idle", 0, 1'b1);

        // Plain encrypt, then plain decrypt.
        bus.start = 1'b1; bus.encrypt = 1'b1;
        run_op("enc", 1'b1, 0, 0, 1'b0, 1'b0);
        step(); check("enc_idle", 0, 1'b1);
        bus.start = 1'b1; bus.encrypt = 1'b0;
        run_op("dec", 1'b0, 0, 0, 1'b0, 1'b0);
        step(); check("dec_idle", 0, 1'b0);

        // Random start/encrypt noise while busy must not disturb the sequence.
        for (int i = 0; i < 3; i++) begin
            m0 = 1'($urandom);
            bus.start = 1'b1; bus.encrypt = m0;
            run_op("noise", m0, 1, 0, 1'b0, 1'b0);
            step(); check("noise_idle", 0, m0);
        end

        // Abort at round 7 of pass 1, then a fresh run completes.
        bus.start = 1'b1; bus.encrypt = 1'b1;
        run_op("abort_r7", 1'b1, 0, 27, 1'b0, 1'b0);
        step(); check("abort_idle", 0, 1'b1);
        bus.start = 1'b1; bus.encrypt = 1'b0;
        run_op("post_abort", 1'b0, 0, 0, 1'b0, 1'b0);
        step(); check("post_abort_idle", 0, 1'b0);

        // Abort at a random point, including during DONE.
        ak = $urandom_range(1, 55);
        m0 = 1'($urandom);
        bus.start = 1'b1; bus.encrypt = m0;
        run_op("abort_rand", m0, 1, ak, 1'b0, 1'b0);
        step(); check("abort_rand_idle", 0, m0);

        // Asynchronous reset between edges in mid-ROUND.
        bus.start = 1'b1; bus.encrypt = 1'b1;
        step(); check("rst_run", 1, 1'b1);
        bus.start = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            step(); check("rst_run", k, 1'b1);
        end
        #2 n_rst = 1'b0;
        #1 check("async_rst", 0, 1'b1);
        step(); check("async_rst_hold", 0, 1'b1);
        #3 n_rst = 1'b1;
        step(); check("rst_release", 0, 1'b1);
        m0 = 1'($urandom);
        bus.start = 1'b1; bus.encrypt = m0;
        run_op("after_rst", m0, 0, 0, 1'b0, 1'b0);
        step(); check("after_rst_idle", 0, m0);

        // Back-to-back with start held high: done at 55, 110, 165.
        m0 = 1'($urandom); m1 = 1'($urandom); m2 = 1'($urandom);
        bus.start = 1'b1; bus.encrypt = m0;
        run_op("b2b0", m0, 2, 0, 1'b1, m1);
        run_op("b2b1", m1, 2, 0, 1'b1, m2);
        run_op("b2b2", m2, 2, 0, 1'b0, 1'b0);
        step(); check("b2b_idle", 0, m2);
        step(); check("b2b_idle2", 0, m2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdes_ctrl.md
# tdes_ctrl

Control sequencer for the Triple-DES core. Runs three 16-round DES passes in EDE order, encrypt or decrypt. Drives the shared round datapath (expansion, S-boxes s_box1..s_box8, P-permutation) and the key-schedule register with load, round-enable, key-select and shift controls. Sits between the host block interface and the round datapath. It holds no data itself, only sequencing state.

## Interface
- ROUNDS, 16, rounds per DES pass (round_idx width fixed at 4)
- PASSES, 3, DES passes per Triple-DES operation
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- encrypt  in  1  1 = Triple-DES encrypt, 0 = decrypt; captured with start
- abort  in  1  synchronous cancel; returns to IDLE next edge, no done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, operation complete
- load_data  out  1  pulse: datapath loads block (IP on pass 0, previous pass result otherwise)
- key_load  out  1  pulse: key register loads PC1(key[key_sel])
- round_en  out  1  datapath performs one Feistel round this cycle
- fp_en  out  1  pulse: final L/R swap + FP, store pass result
- round_idx  out  4  current round 0..15 (0 outside ROUND)
- pass_idx  out  2  current pass 0..2
- key_sel  out  2  key for this pass: 0=K1, 1=K2, 2=K3
- pass_dec  out  1  1 = current pass is DES-decrypt
- shift_amt  out  2  key-register rotate amount for this round (0, 1 or 2)
- shift_left  out  1  1 = rotate left (encrypt pass), 0 = rotate right

## Operation
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE -> LOAD on start. Latch mode = encrypt. Set pass_idx = 0.
- LOAD: 1 cycle. Outputs load_data = 1, key_load = 1. Next state is ROUND with round_idx = 0.
- ROUND: 16 cycles with round_en = 1. round_idx increments each cycle. After round_idx = 15, go to FINAL.
- FINAL: 1 cycle with fp_en = 1.
  - If pass_idx < 2: increment pass_idx and go to LOAD.
  - If pass_idx = 2: go to DONE.
- DONE: done = 1 for 1 cycle, then IDLE.
- Pass mapping, with mode latched:
  - Encrypt: pass 0 = E/K1, pass 1 = D/K2, pass 2 = E/K3.
  - Decrypt: pass 0 = D/K3, pass 1 = E/K2, pass 2 = D/K1.
- shift_left = ~pass_dec. shift_amt is 0 outside ROUND.
  - Encrypt pass, round r: LSHIFT[r] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt pass: shift_amt = 0 at r = 0, else LSHIFT[16-r]. This gives 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Subkey convention: the datapath applies the rotation combinationally, uses the result as the round subkey, and registers it.
- start while busy is ignored. encrypt changes while busy have no effect.
- abort has priority over all transitions in any non-IDLE state. It gives IDLE at the next edge with done = 0.
- Same-cycle start + abort in IDLE: start wins (abort is meaningful only when busy).

## Timing
- Reset (async assert, any state): state = IDLE. pass_idx = 0, round_idx = 0, mode = 1. All outputs 0, and key_sel = 0 when idle.
- start sampled high at edge t:
  - LOAD for pass p occupies the cycle after edge t+18p.
  - ROUND occupies t+18p+1 .. t+18p+16.
  - FINAL follows at t+18p+17.
  - done is high in the cycle after edge t+54. busy is high from after edge t through that cycle.
- Next start accepted at edge t+55 (back-to-back throughput: 55 cycles per block).
- All outputs are registered-state decodes: glitch-free and valid for the whole cycle.

## Structure
- Package des_pkg holds:
  - state enum `tdes_state_t`;
  - localparam LSHIFT table (16 × 2-bit);
  - constants ROUNDS_PER_PASS = 16 and NUM_PASSES = 3;
  - pass-mapping function returning {key_sel, pass_dec} from (mode, pass_idx).
- One combinational sub-module, des_shift_lut: in round_idx, pass_dec; out shift_amt. Everything else lives in tdes_ctrl.

## Test plan
- Reset, then encrypt start: load_data at cycle 1; round_en cycles 2–17; fp_en at 18, 36, 54; done at 55 only. key_sel sequence 0,1,2 and pass_dec sequence 0,1,0.
- Decrypt start: key_sel 2,1,0 and pass_dec 1,0,1. Pass 0 shift_amt 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with shift_left = 0. Pass 1 shift_amt 1,1,2,…,1 with shift_left = 1.
- Toggle encrypt and pulse start during pass 1: no change to key_sel/pass_dec sequence, single done at cycle 55.
- abort at round_idx = 7 of pass 1 -> IDLE next cycle, busy = 0, done never asserts, fresh start then completes normally.
- n_rst asserted mid-ROUND (asynchronously, between edges) -> all outputs 0 immediately; after release, IDLE, and start runs full 55-cycle sequence.
- Back-to-back: start held high continuously -> done pulses at cycles 55, 110, 165; no extra or merged pulses.
